// File: rtl/regfile_write_queue.sv
// ============================================================================
// Module      : regfile_write_queue
// Description : In-order write buffer between writeback and the register file,
//               draining one write per cycle and reporting pending writes to
//               decode. Define WBQ_FORWARD_EN to return youngest pending data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_addr,
    input  logic [DW-1:0]            in_data,
    input  logic                     drain_en,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_waddr,
    output logic [DW-1:0]            rf_wdata,
    input  logic [AW-1:0]            rd_addr1,
    input  logic [AW-1:0]            rd_addr2,
    output logic                     pend1,
    output logic                     pend2,
    output logic [DW-1:0]            fwd_data1,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] mem_addr [DEPTH];
    logic [DW-1:0] mem_data [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] idx;
    logic          push;
    logic          store;
    logic          pop;

    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid & in_ready;
    // Writes to r0 complete the handshake but never occupy an entry.
    assign store    = push & (in_addr != '0);
    assign pop      = (count != '0) & drain_en;

    always_ff @(posedge clk) begin
        if (store) begin
            mem_addr[wr_ptr] <= in_addr;
            mem_data[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rf_we    <= 1'b1;
                rf_waddr <= mem_addr[rd_ptr];
                rf_wdata <= mem_data[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end else begin
                rf_we    <= 1'b0;
            end
            count <= count + CW'(store) - CW'(pop);
        end
    end

    // Scan oldest to newest so later matches override: the youngest write wins,
    // and the rf_* stage (older than every queue entry) has lowest priority.
    always_comb begin
        pend1     = 1'b0;
        pend2     = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        idx       = '0;
        if (rf_we && (rf_waddr == rd_addr1)) begin
            pend1 = 1'b1;
`ifdef WBQ_FORWARD_EN
            fwd_data1 = rf_wdata;
`endif
        end
        if (rf_we && (rf_waddr == rd_addr2)) begin
            pend2 = 1'b1;
`ifdef WBQ_FORWARD_EN
            fwd_data2 = rf_wdata;
`endif
        end
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (CW'(k) < count) begin
                if (mem_addr[idx] == rd_addr1) begin
                    pend1 = 1'b1;
`ifdef WBQ_FORWARD_EN
                    fwd_data1 = mem_data[idx];
`endif
                end
                if (mem_addr[idx] == rd_addr2) begin
                    pend2 = 1'b1;
`ifdef WBQ_FORWARD_EN
                    fwd_data2 = mem_data[idx];
`endif
                end
            end
        end
        if (rd_addr1 == '0) begin
            pend1     = 1'b0;
            fwd_data1 = '0;
        end
        if (rd_addr2 == '0) begin
            pend2     = 1'b0;
            fwd_data2 = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regfile_write_queue.sv
// ============================================================================
// Module      : tb_regfile_write_queue
// Description : Directed and random stimulus against a queue-based model of the
//               register-file write queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_write_queue;

    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    logic [AW-1:0]          in_addr;
    logic [DW-1:0]          in_data;
    logic                   drain_en;
    logic                   rf_we;
    logic [AW-1:0]          rf_waddr;
    logic [DW-1:0]          rf_wdata;
    logic [AW-1:0]          rd_addr1;
    logic [AW-1:0]          rd_addr2;
    logic                   pend1;
    logic                   pend2;
    logic [DW-1:0]          fwd_data1;
    logic [DW-1:0]          fwd_data2;
    logic [$clog2(DEPTH):0] count;

    regfile_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .drain_en(drain_en),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .pend1(pend1), .pend2(pend2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count)
    );

    always #5 clk = ~clk;

    // Reference state: pending writes in push order plus the regfile stage.
    wr_t           q[$];
    logic          m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            tests;
    int            fails;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup(input logic [AW-1:0] ra, output logic p, output logic [DW-1:0] f);
        p = 1'b0;
        f = '0;
        if (ra != 0) begin
            if (m_we && m_waddr == ra) begin
                p = 1'b1;
                f = m_wdata;
            end
            foreach (q[i]) begin
                if (q[i].a == ra) begin
                    p = 1'b1;
                    f = q[i].d;
                end
            end
        end
`ifndef WBQ_FORWARD_EN
        f = '0;
`endif
    endtask

    task automatic step(input logic r, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic dr,
                        input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
        logic          p;
        logic [DW-1:0] f;
        logic          ready;
        wr_t           w;
        rst = r; in_valid = v; in_addr = a; in_data = d; drain_en = dr;
        rd_addr1 = ra1; rd_addr2 = ra2;
        #1;
        ready = (q.size() < DEPTH);
        check("in_ready", DW'(in_ready), DW'(ready));
        check("count", DW'(count), DW'(q.size()));
        model_lookup(ra1, p, f);
        check("pend1", DW'(pend1), DW'(p));
        check("fwd_data1", fwd_data1, f);
        model_lookup(ra2, p, f);
        check("pend2", DW'(pend2), DW'(p));
        check("fwd_data2", fwd_data2, f);
        @(posedge clk);
        if (r) begin
            q.delete();
            m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        end else begin
            if (dr && q.size() != 0) begin
                m_we = 1'b1; m_waddr = q[0].a; m_wdata = q[0].d;
                void'(q.pop_front());
            end else begin
                m_we = 1'b0;
            end
            if (v && ready && a != 0) begin
                w.a = a; w.d = d;
                q.push_back(w);
            end
        end
        #1;
        check("rf_we", DW'(rf_we), DW'(m_we));
        check("rf_waddr", DW'(rf_waddr), DW'(m_waddr));
        check("rf_wdata", rf_wdata, m_wdata);
    endtask

    initial begin
        tests = 0; fails = 0;
        m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; drain_en = 1'b0;
        rd_addr1 = '0; rd_addr2 = '0;
        @(posedge clk); #1;

        // Reset then idle
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 3, 6);

        // Single write drains two edges after the push
        step(0, 1, 6, 50, 1, 6, 0);
        step(0, 0, 0, 0, 1, 6, 0);
        check("t2_rf_waddr", DW'(rf_waddr), 32'd6);
        step(0, 0, 0, 0, 1, 6, 0);

        // Fill while frozen, overflow ignored, then drain in order
        step(0, 1, 1, 32'h11, 0, 1, 4);
        step(0, 1, 2, 32'h22, 0, 2, 3);
        step(0, 1, 3, 32'h33, 0, 3, 1);
        step(0, 1, 4, 32'h44, 0, 4, 2);
        check("t3_count_full", DW'(count), 32'd4);
        step(0, 1, 5, 32'h55, 0, 5, 4);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 4, 1);

        // Two writes to one register, youngest forwarded
        step(0, 1, 2, 1, 0, 2, 0);
        step(0, 1, 2, 7, 0, 2, 0);
        step(0, 0, 0, 0, 0, 2, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 2, 2);

        // r0 write accepted but not stored
        step(0, 1, 0, 32'hDEAD, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0);

        // Reset mid-drain discards remaining entries
        step(0, 1, 7, 32'h70, 0, 7, 8);
        step(0, 1, 8, 32'h80, 0, 7, 8);
        step(0, 1, 9, 32'h90, 0, 7, 9);
        step(0, 0, 0, 0, 1, 7, 8);
        step(1, 0, 0, 0, 1, 8, 9);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8, 9);

        // Random traffic with small address range for collisions and r0
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 9) < 7),
                 AW'($urandom_range(0, 7)),
                 DW'($urandom),
                 ($urandom_range(0, 9) < 6),
                 AW'($urandom_range(0, 7)),
                 AW'($urandom_range(0, 7)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
